// File: rtl/instr_decode_stage.sv
// Decode stage: splits 9-bit instruction words into ALU/control fields and presents them
// through a 2-entry registered skid buffer. Optional perf counters: define DECODE_PERF_EN.
module instr_decode_stage #(
  parameter int unsigned IW    = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_alu_op,
  output logic [2:0]    out_rd,
  output logic [2:0]    out_rs,
  output logic [2:0]    out_imm,
  output logic          out_mem_rd,
  output logic          out_mem_wr,
  output logic          out_reg_wr,
  output logic          out_cmp,
  output logic [1:0]    out_shsrc,
  output logic          out_branch,
  output logic          out_bsense
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]   perf_dec,
  output logic [31:0]   perf_stall,
  output logic [15:0]   perf_flush
`endif
);

  localparam int unsigned FW = 3;

  typedef enum logic [FW-1:0] {
    OP_LW    = 3'd0,
    OP_SW    = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_CEQ   = 3'd4,
    OP_CLT   = 3'd5,
    OP_SEI   = 3'd6,
    OP_OTHER = 3'd7
  } op_e;

  typedef enum logic [FW-1:0] {
    FN_SHIFTL_X = 3'd0,
    FN_SHIFTL_F = 3'd1,
    FN_SHIFTL_O = 3'd2,
    FN_SHIFTR_X = 3'd3,
    FN_SHIFTR_F = 3'd4,
    FN_SHIFTR_O = 3'd5,
    FN_B0       = 3'd6,
    FN_B1       = 3'd7
  } fn_e;

  typedef enum logic [FW-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_LSH = 3'd2,
    ALU_RSH = 3'd3,
    ALU_AND = 3'd4
  } alu_e;

  localparam logic [1:0] SH_X    = 2'd0;
  localparam logic [1:0] SH_F    = 2'd1;
  localparam logic [1:0] SH_O    = 2'd2;
  localparam logic [1:0] SH_NONE = 2'd3;

  typedef struct packed {
    logic [FW-1:0] alu_op;
    logic [FW-1:0] rd;
    logic [FW-1:0] rs;
    logic [FW-1:0] imm;
    logic          mem_rd;
    logic          mem_wr;
    logic          reg_wr;
    logic          cmp;
    logic [1:0]    shsrc;
    logic          branch;
    logic          bsense;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  // Field layout is hard-wired for 9-bit words and a two-deep buffer.
  if (IW != 32'd9 || DEPTH != 32'd2) begin : g_cfg_err
    $error("instr_decode_stage: only IW=9 and DEPTH=2 are supported");
  end

  function automatic dec_t decode(input logic [IW-1:0] w);
    dec_t d;
    op_e  op;
    fn_e  fn;
    d       = '0;
    op      = op_e'(w[8:6]);
    fn      = fn_e'(w[5:3]);
    d.rd    = w[5:3];
    d.rs    = w[2:0];
    d.imm   = w[2:0];
    d.shsrc = SH_NONE;
    case (op)
      OP_LW: begin
        d.alu_op = ALU_ADD;
        d.mem_rd = 1'b1;
        d.reg_wr = 1'b1;
      end
      OP_SW: begin
        d.alu_op = ALU_ADD;
        d.mem_wr = 1'b1;
      end
      OP_ADD, OP_SEI: begin
        d.alu_op = ALU_ADD;
        d.reg_wr = 1'b1;
      end
      OP_SUB: begin
        d.alu_op = ALU_SUB;
        d.reg_wr = 1'b1;
      end
      OP_CEQ, OP_CLT: begin
        d.alu_op = ALU_SUB;
        d.reg_wr = 1'b1;
        d.cmp    = 1'b1;
      end
      OP_OTHER: begin
        // fn occupies the rd slot, so no destination register is named
        d.rd = '0;
        case (fn)
          FN_SHIFTL_X: begin d.alu_op = ALU_LSH; d.reg_wr = 1'b1; d.shsrc = SH_X; end
          FN_SHIFTL_F: begin d.alu_op = ALU_LSH; d.reg_wr = 1'b1; d.shsrc = SH_F; end
          FN_SHIFTL_O: begin d.alu_op = ALU_LSH; d.reg_wr = 1'b1; d.shsrc = SH_O; end
          FN_SHIFTR_X: begin d.alu_op = ALU_RSH; d.reg_wr = 1'b1; d.shsrc = SH_X; end
          FN_SHIFTR_F: begin d.alu_op = ALU_RSH; d.reg_wr = 1'b1; d.shsrc = SH_F; end
          FN_SHIFTR_O: begin d.alu_op = ALU_RSH; d.reg_wr = 1'b1; d.shsrc = SH_O; end
          FN_B0: begin
            d.alu_op = ALU_AND;
            d.branch = 1'b1;
          end
          FN_B1: begin
            d.alu_op = ALU_AND;
            d.branch = 1'b1;
            d.bsense = 1'b1;
          end
        endcase
      end
    endcase
    return d;
  endfunction

  state_e state_q;
  dec_t   head_q;
  dec_t   tail_q;
  logic   in_ready_q;
  logic   out_valid_q;
  dec_t   dec_in;
  logic   enq;
  logic   deq;

  assign dec_in = decode(in_instr);
  assign enq    = in_valid & in_ready_q;
  assign deq    = out_valid_q & out_ready;

  // Skid FSM; in_ready/out_valid are registered alongside the occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (enq) begin
            head_q      <= dec_in;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (enq && deq) begin
            head_q <= dec_in;
          end else if (enq) begin
            tail_q     <= dec_in;
            state_q    <= S_FULL;
            in_ready_q <= 1'b0;
          end else if (deq) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (deq) begin
            head_q     <= tail_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_alu_op = head_q.alu_op;
  assign out_rd     = head_q.rd;
  assign out_rs     = head_q.rs;
  assign out_imm    = head_q.imm;
  assign out_mem_rd = head_q.mem_rd;
  assign out_mem_wr = head_q.mem_wr;
  assign out_reg_wr = head_q.reg_wr;
  assign out_cmp    = head_q.cmp;
  assign out_shsrc  = head_q.shsrc;
  assign out_branch = head_q.branch;
  assign out_bsense = head_q.bsense;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_dec_q;
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Saturating event counters; a dequeue coinciding with flush is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_dec_q   <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (deq && !flush && perf_dec_q != '1) begin
        perf_dec_q <= perf_dec_q + 32'd1;
      end
      if (out_valid_q && !out_ready && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (flush && state_q != S_EMPTY && perf_flush_q != '1) begin
        perf_flush_q <= perf_flush_q + 16'd1;
      end
    end
  end

  assign perf_dec   = perf_dec_q;
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed + random bench for instr_decode_stage with an in-order scoreboard of decoded records.
module tb_instr_decode_stage;

  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;
  localparam logic [2:0] A_LSH = 3'd2;
  localparam logic [2:0] A_RSH = 3'd3;
  localparam logic [2:0] A_AND = 3'd4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_alu_op;
  logic [2:0] out_rd;
  logic [2:0] out_rs;
  logic [2:0] out_imm;
  logic       out_mem_rd;
  logic       out_mem_wr;
  logic       out_reg_wr;
  logic       out_cmp;
  logic [1:0] out_shsrc;
  logic       out_branch;
  logic       out_bsense;
`ifdef DECODE_PERF_EN
  logic [31:0] perf_dec;
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  instr_decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu_op (out_alu_op),
    .out_rd     (out_rd),
    .out_rs     (out_rs),
    .out_imm    (out_imm),
    .out_mem_rd (out_mem_rd),
    .out_mem_wr (out_mem_wr),
    .out_reg_wr (out_reg_wr),
    .out_cmp    (out_cmp),
    .out_shsrc  (out_shsrc),
    .out_branch (out_branch),
    .out_bsense (out_bsense)
`ifdef DECODE_PERF_EN
    ,
    .perf_dec   (perf_dec),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int m_dec   = 0;
  int m_stall = 0;
  int m_flush = 0;
  logic [19:0] sb_q[$];

  // Reference decode: {alu, rd, rs, imm, mem_rd, mem_wr, reg_wr, cmp, shsrc, branch, bsense}
  function automatic logic [19:0] m_decode(input logic [8:0] w);
    logic [2:0] op, fn, alu, rd;
    logic [1:0] sh;
    logic       other;
    op    = w[8:6];
    fn    = w[5:3];
    other = (op == 3'd7);
    if (other) alu = (fn < 3'd3) ? A_LSH : (fn < 3'd6) ? A_RSH : A_AND;
    else       alu = (op == 3'd3 || op == 3'd4 || op == 3'd5) ? A_SUB : A_ADD;
    rd = other ? 3'd0 : fn;
    sh = (other && fn < 3'd6) ? 2'(fn % 3'd3) : 2'd3;
    return {alu, rd, w[2:0], w[2:0],
            op == 3'd0, op == 3'd1,
            other ? (fn < 3'd6) : (op != 3'd1),
            op == 3'd4 || op == 3'd5,
            sh, other && fn >= 3'd6, other && fn == 3'd7};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {out_alu_op, out_rd, out_rs, out_imm, out_mem_rd, out_mem_wr,
            out_reg_wr, out_cmp, out_shsrc, out_branch, out_bsense};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check handshake state against the model, account the transfer, advance.
  task automatic cycle();
    logic [19:0] e;
    logic        m_valid, m_ready;
    #1;
    m_valid = (sb_q.size() != 0);
    m_ready = (sb_q.size() < 2);
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid && !out_ready) m_stall++;
    if (flush) begin
      if (m_valid) m_flush++;
      sb_q.delete();
    end else begin
      if (m_valid && out_ready) begin
        e = sb_q.pop_front();
        chk("head_record", 32'(obs_vec()), 32'(e));
        m_dec++;
      end
      if (in_valid && m_ready) sb_q.push_back(m_decode(in_instr));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 8 && (out_valid || sb_q.size() != 0); i++) cycle();
    chk("drained_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    sb_q.delete();
    m_dec = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    do_reset();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_fields", 32'(obs_vec()), 32'd0);

    // ADD r1, r2 appears the cycle after acceptance
    in_valid = 1'b1; in_instr = 9'b010_001_010; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_fields", 32'(obs_vec()),
        32'({A_ADD, 3'd1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0}));
    drain();

    // backpressure: third word is held while the buffer is full
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 9'b000_011_101;
    cycle();
    in_instr = 9'b100_110_001;
    cycle();
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    in_instr = 9'b111_010_110;
    cycle();
    cycle();
    chk("t2_head_frozen", 32'(obs_vec()), 32'(m_decode(9'b000_011_101)));
    out_ready = 1'b1;
    cycle();
    cycle();
    drain();

    // branch on fnB1, then right shift with O fill
    in_valid = 1'b1; in_instr = 9'b111_111_000;
    cycle();
    chk("t3_branch", 32'(out_branch), 32'd1);
    chk("t3_bsense", 32'(out_bsense), 32'd1);
    chk("t3_alu_and", 32'(out_alu_op), 32'(A_AND));
    chk("t3_reg_wr", 32'(out_reg_wr), 32'd0);
    in_instr = 9'b111_101_011;
    cycle();
    in_valid = 1'b0;
    chk("t3_alu_rsh", 32'(out_alu_op), 32'(A_RSH));
    chk("t3_shsrc", 32'(out_shsrc), 32'd2);
    drain();

    // flush from FULL with a word offered and head accepted
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b011_001_001;
    cycle();
    in_instr = 9'b101_010_010;
    cycle();
    flush = 1'b1; out_ready = 1'b1; in_instr = 9'b110_011_011;
    cycle();
    idle_inputs();
    chk("t4_flush_valid", 32'(out_valid), 32'd0);
    chk("t4_flush_ready", 32'(in_ready), 32'd1);
    cycle();
    // flush from ONE drops the word that is being accepted
    in_valid = 1'b1; in_instr = 9'b001_100_111;
    cycle();
    flush = 1'b1; out_ready = 1'b0; in_instr = 9'b010_101_100;
    cycle();
    idle_inputs();
    cycle();
    chk("t4_dropped_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_instr = 9'b100_001_011; out_ready = 1'b1;
    cycle();
    drain();

    // asynchronous reset between edges while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b000_111_111;
    cycle();
    in_instr = 9'b110_110_110;
    cycle();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_ready", 32'(in_ready), 32'd1);
    chk("t5_async_fields", 32'(obs_vec()), 32'd0);
    sb_q.delete();
    m_dec = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_instr  = 9'($urandom_range(0, 511));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    drain();

`ifdef DECODE_PERF_EN
    chk("perf_dec_model", perf_dec, 32'(m_dec));
    chk("perf_stall_model", perf_stall, 32'(m_stall));
    chk("perf_flush_model", 32'(perf_flush), 32'(m_flush));
    do_reset();
    chk("perf_dec_reset", perf_dec, 32'd0);
    in_valid = 1'b1; in_instr = 9'b010_001_001; out_ready = 1'b0;
    cycle();
    in_instr = 9'b010_010_010;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b1; in_instr = 9'b011_011_011;
    cycle();
    in_instr = 9'b011_100_100;
    cycle();
    in_instr = 9'b011_101_101;
    cycle();
    in_valid = 1'b0;
    cycle();
    in_valid = 1'b1; in_instr = 9'b001_110_110;
    cycle();
    in_valid = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("perf_dec", perf_dec, 32'd5);
    chk("perf_stall", perf_stall, 32'd3);
    chk("perf_flush", 32'(perf_flush), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
